// File: rtl/knight_sprite_addr_gen.sv
// Knight sprite hit test and ROM address generator with vsync-paced animation.
// Optional macro KNIGHT_FLIP_EN: mirror columns when the knight faces left.
module knight_sprite_addr_gen #(
   parameter int SPR_W      = 50,
   parameter int SPR_H      = 64,
   parameter int NUM_FRAMES = 6,
   parameter int FRAME_DIV  = 8,
   parameter int ADDR_W     = 15
) (
   input  logic              vga_clk,
   input  logic              Reset,
   input  logic              vs,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic [9:0]        KnightX,
   input  logic [9:0]        KnightY,
   input  logic              facing_left,
   input  logic              anim_en,
   output logic [ADDR_W-1:0] rom_address,
   output logic              sprite_on,
   output logic [2:0]        frame_idx
);

   localparam int DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam int FRAME_SZ = SPR_W * SPR_H;

   logic             vs_q;
   logic             tick;
   logic [9:0]       pos_x, pos_y;
   logic             face_q;
   logic             mirror;
   logic [DIV_W-1:0] div_cnt;

   logic [10:0]       dx, dy, px, py;
   logic [10:0]       col, row, mcol;
   logic              hit;
   logic [ADDR_W-1:0] addr_sum;

   assign tick = vs_q & ~vs;

`ifdef KNIGHT_FLIP_EN
   assign mirror = face_q;
`else
   assign mirror = 1'b0 & face_q;
`endif

   // 11-bit compares keep pos+W from wrapping near the right/bottom edge
   assign dx  = {1'b0, DrawX};
   assign dy  = {1'b0, DrawY};
   assign px  = {1'b0, pos_x};
   assign py  = {1'b0, pos_y};
   assign hit = (dx >= px) && (dx < px + 11'(SPR_W)) &&
                (dy >= py) && (dy < py + 11'(SPR_H));

   assign col  = dx - px;
   assign row  = dy - py;
   assign mcol = mirror ? (11'(SPR_W - 1) - col) : col;

   assign addr_sum = ADDR_W'(32'(frame_idx) * 32'(FRAME_SZ) +
                             32'(row) * 32'(SPR_W) + 32'(mcol));

   always_ff @(posedge vga_clk or posedge Reset) begin
      if (Reset) begin
         vs_q        <= 1'b1;
         pos_x       <= '0;
         pos_y       <= '0;
         face_q      <= 1'b0;
         div_cnt     <= '0;
         frame_idx   <= '0;
         rom_address <= '0;
         sprite_on   <= 1'b0;
      end else begin
         vs_q <= vs;

         // position only moves at frame boundaries so a frame never tears
         if (tick) begin
            pos_x  <= KnightX;
            pos_y  <= KnightY;
            face_q <= facing_left;
         end

         if (!anim_en) begin
            div_cnt   <= '0;
            frame_idx <= '0;
         end else if (tick) begin
            if (div_cnt == DIV_W'(FRAME_DIV - 1)) begin
               div_cnt   <= '0;
               frame_idx <= (frame_idx == 3'(NUM_FRAMES - 1)) ? 3'd0 : frame_idx + 3'd1;
            end else begin
               div_cnt <= div_cnt + 1'b1;
            end
         end

         sprite_on   <= hit;
         rom_address <= hit ? addr_sum : '0;
      end
   end

endmodule

// File: tb/tb_knight_sprite_addr_gen.sv
// Scoreboard bench for knight_sprite_addr_gen: probes push expectations, monitor pops.
module tb_knight_sprite_addr_gen;

   logic        vga_clk = 1'b0;
   logic        Reset;
   logic        vs;
   logic [9:0]  DrawX, DrawY, KnightX, KnightY;
   logic        facing_left, anim_en;
   logic [14:0] rom_address;
   logic        sprite_on;
   logic [2:0]  frame_idx;

   typedef struct packed {
      logic        on;
      logic [14:0] addr;
      logic [2:0]  frame;
   } exp_t;

   exp_t exp_q[$];
   logic issue = 1'b0;
   logic issued_d = 1'b0;
   int   total = 0;
   int   bad = 0;

`ifdef KNIGHT_FLIP_EN
   localparam bit FLIP = 1'b1;
`else
   localparam bit FLIP = 1'b0;
`endif

   knight_sprite_addr_gen dut (
      .vga_clk(vga_clk), .Reset(Reset), .vs(vs),
      .DrawX(DrawX), .DrawY(DrawY), .KnightX(KnightX), .KnightY(KnightY),
      .facing_left(facing_left), .anim_en(anim_en),
      .rom_address(rom_address), .sprite_on(sprite_on), .frame_idx(frame_idx)
   );

   always #5 vga_clk = ~vga_clk;

   always @(posedge vga_clk) issued_d <= issue;

   // monitor: one registered response per issued probe
   always @(negedge vga_clk) begin
      if (issued_d) begin
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty: response with no expectation queued");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (sprite_on !== e.on) begin
               bad++;
               $display("FAIL sprite_on: got %0b want %0b (t=%0t)", sprite_on, e.on, $time);
            end
            total++;
            if (rom_address !== e.addr) begin
               bad++;
               $display("FAIL rom_address: got %0d want %0d (t=%0t)", rom_address, e.addr, $time);
            end
            total++;
            if (frame_idx !== e.frame) begin
               bad++;
               $display("FAIL frame_idx: got %0d want %0d (t=%0t)", frame_idx, e.frame, $time);
            end
         end
      end
   end

   task automatic probe(input int x, input int y, input bit on, input int addr, input int fr);
      exp_t e;
      @(negedge vga_clk);
      DrawX = 10'(x);
      DrawY = 10'(y);
      e.on = on; e.addr = 15'(addr); e.frame = 3'(fr);
      exp_q.push_back(e);
      issue = 1'b1;
      @(negedge vga_clk);
      issue = 1'b0;
   endtask

   task automatic vs_edges(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge vga_clk) vs = 1'b0;
         @(negedge vga_clk) vs = 1'b1;
      end
   endtask

   task automatic chk_now(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset = 1'b1; vs = 1'b1; DrawX = '0; DrawY = '0;
      KnightX = 10'd100; KnightY = 10'd200; facing_left = 1'b0; anim_en = 1'b0;
      repeat (3) @(negedge vga_clk);
      chk_now("reset_sprite_on", int'(sprite_on), 0);
      chk_now("reset_rom_address", int'(rom_address), 0);
      chk_now("reset_frame_idx", int'(frame_idx), 0);
      Reset = 1'b0;

      // latch (100,200) and probe box corners and edges
      vs_edges(1);
      probe(100, 200, 1, 0, 0);
      probe(149, 263, 1, 3199, 0);
      probe(150, 263, 0, 0, 0);
      probe(99, 200, 0, 0, 0);
      probe(100, 264, 0, 0, 0);
      probe(100, 199, 0, 0, 0);

      // reset mid-line clears outputs at once
      probe(120, 210, 1, 520, 0);
      anim_en = 1'b1;
      #2 Reset = 1'b1;
      #1;
      chk_now("midreset_sprite_on", int'(sprite_on), 0);
      chk_now("midreset_rom_address", int'(rom_address), 0);
      chk_now("midreset_frame_idx", int'(frame_idx), 0);
      @(negedge vga_clk) Reset = 1'b0;
      repeat (4) @(negedge vga_clk);
      // position back at 0,0 and no frame advance without a vsync edge
      probe(0, 0, 1, 0, 0);
      probe(100, 200, 0, 0, 0);

      // animation pacing: 8 edges per step, 6 frames
      vs_edges(7);
      probe(100, 200, 1, 0, 0);
      vs_edges(1);
      probe(100, 200, 1, 3200, 1);
      vs_edges(8);
      probe(100, 200, 1, 6400, 2);
      probe(101, 201, 1, 6451, 2);
      vs_edges(32);
      probe(100, 200, 1, 0, 0);

      // mirroring (edge 49: div 1)
      facing_left = 1'b1;
      vs_edges(1);
      probe(100, 200, 1, FLIP ? 49 : 0, 0);
      probe(149, 200, 1, FLIP ? 0 : 49, 0);

      // right-edge clipping (edge 50: div 2)
      facing_left = 1'b0;
      KnightX = 10'd620;
      vs_edges(1);
      probe(639, 200, 1, 19, 0);
      probe(0, 200, 0, 0, 0);
      probe(5, 200, 0, 0, 0);
      probe(11, 200, 0, 0, 0);
      // mid-frame move ignored until the next edge
      KnightX = 10'd100;
      probe(639, 200, 1, 19, 0);
      probe(100, 200, 0, 0, 0);
      vs_edges(1);  // div 3
      probe(100, 200, 1, 0, 0);

      // reach frame 3, then drop anim_en on a tick
      vs_edges(5);
      probe(100, 200, 1, 3200, 1);
      vs_edges(16);
      probe(100, 200, 1, 9600, 3);
      vs_edges(3);
      @(negedge vga_clk) begin vs = 1'b0; anim_en = 1'b0; end
      @(negedge vga_clk) begin vs = 1'b1; anim_en = 1'b1; end
      probe(100, 200, 1, 0, 0);
      // div_cnt was cleared: 7 more edges stay at 0, the 8th steps
      vs_edges(7);
      probe(100, 200, 1, 0, 0);
      vs_edges(1);
      probe(100, 200, 1, 3200, 1);

      repeat (3) @(negedge vga_clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
